// File: rtl/add_sub_pkg.sv
// Shared definitions for the Q8.8 add/subtract arbiter: datapath width,
// saturation limits and FSM state encoding.
package add_sub_pkg;

  // Q8.8 operand width.
  localparam int unsigned QW = 16;

  localparam logic [15:0] SAT_POS = 16'h7FFF;
  localparam logic [15:0] SAT_NEG = 16'h8000;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StCalc = 2'd1,
    StResp = 2'd2
  } state_e;

endpackage

// File: rtl/add_sub.sv
// Shared Add_Sub core: sum = a + b + cin, modulo 2^W.
module add_sub #(
  parameter int unsigned W = 16
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic [W-1:0] sum
);

  assign sum = a + b + {{(W-1){1'b0}}, cin};

endmodule

// File: rtl/add_sub_rr_pick.sv
// Round-robin picker: first set request after ptr, wrapping, as one-hot
// grant plus encoded index.
module add_sub_rr_pick #(
  parameter int unsigned NREQ = 4,
  parameter int unsigned IDW  = 2
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  ptr,
  output logic [NREQ-1:0] grant,
  output logic [IDW-1:0]  idx,
  output logic            any
);

  logic           found;
  logic [IDW-1:0] k;

  always_comb begin
    grant = '0;
    idx   = '0;
    found = 1'b0;
    k     = '0;
    for (int unsigned off = 1; off <= NREQ; off++) begin
      k = IDW'((32'(ptr) + off) % NREQ);
      if (!found && req[k]) begin
        found    = 1'b1;
        grant[k] = 1'b1;
        idx      = k;
      end
    end
  end

  assign any = found;

endmodule

// File: rtl/add_sub_arbiter.sv
// Round-robin front end sharing one Add_Sub core between NREQ requesters,
// with tagged valid/ready response, optional saturation and sticky overflow.
module add_sub_arbiter
  import add_sub_pkg::*;
#(
  parameter int unsigned NREQ = 4,
  parameter int unsigned W    = QW,
  parameter int unsigned IDW  = 2,
  parameter bit          SAT  = 1'b0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NREQ-1:0]   req_valid,
  output logic [NREQ-1:0]   req_ready,
  input  logic [NREQ*W-1:0] req_a,
  input  logic [NREQ*W-1:0] req_b,
  input  logic [NREQ-1:0]   req_sub,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [IDW-1:0]    rsp_id,
  output logic [W-1:0]      rsp_result,
  output logic              rsp_overflow,
  output logic              ovf_sticky,
  input  logic              ovf_clr
);

  localparam logic [W-1:0] SatPos = (W == QW) ? W'(SAT_POS) : {1'b0, {(W-1){1'b1}}};
  localparam logic [W-1:0] SatNeg = (W == QW) ? W'(SAT_NEG) : {1'b1, {(W-1){1'b0}}};

  state_e         state_q;
  logic [IDW-1:0] ptr_q;
  logic [W-1:0]   a_q, b_q;
  logic           sub_q;
  logic [IDW-1:0] id_q;
  logic           rsp_valid_q, rsp_overflow_q, ovf_sticky_q;
  logic [IDW-1:0] rsp_id_q;
  logic [W-1:0]   rsp_result_q;

  logic [NREQ-1:0] grant;
  logic [IDW-1:0]  gidx;
  logic            any_req;

  add_sub_rr_pick #(
    .NREQ(NREQ),
    .IDW (IDW)
  ) u_pick (
    .req  (req_valid),
    .ptr  (ptr_q),
    .grant(grant),
    .idx  (gidx),
    .any  (any_req)
  );

  assign req_ready = (state_q == StIdle) ? grant : '0;

  // Subtraction as A + ~B + 1 through the shared core.
  logic [W-1:0] b_eff, core_sum, res_fin;
  logic         ovf;

  assign b_eff = sub_q ? ~b_q : b_q;

  add_sub #(
    .W(W)
  ) u_core (
    .a  (a_q),
    .b  (b_eff),
    .cin(sub_q),
    .sum(core_sum)
  );

  assign ovf     = (a_q[W-1] == b_eff[W-1]) && (core_sum[W-1] != a_q[W-1]);
  assign res_fin = (SAT && ovf) ? (a_q[W-1] ? SatNeg : SatPos) : core_sum;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= StIdle;
      ptr_q          <= IDW'(NREQ - 1);
      a_q            <= '0;
      b_q            <= '0;
      sub_q          <= 1'b0;
      id_q           <= '0;
      rsp_valid_q    <= 1'b0;
      rsp_id_q       <= '0;
      rsp_result_q   <= '0;
      rsp_overflow_q <= 1'b0;
      ovf_sticky_q   <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (any_req) begin
            a_q     <= req_a[gidx*W +: W];
            b_q     <= req_b[gidx*W +: W];
            sub_q   <= req_sub[gidx];
            id_q    <= gidx;
            state_q <= StCalc;
          end
        end
        StCalc: begin
          rsp_result_q   <= res_fin;
          rsp_overflow_q <= ovf;
          rsp_id_q       <= id_q;
          rsp_valid_q    <= 1'b1;
          state_q        <= StResp;
        end
        StResp: begin
          if (rsp_ready) begin
            ptr_q       <= rsp_id_q;
            rsp_valid_q <= 1'b0;
            state_q     <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase

      // A new overflow beats a simultaneous clear.
      if (state_q == StCalc && ovf) begin
        ovf_sticky_q <= 1'b1;
      end else if (ovf_clr) begin
        ovf_sticky_q <= 1'b0;
      end
    end
  end

  assign rsp_valid    = rsp_valid_q;
  assign rsp_id       = rsp_id_q;
  assign rsp_result   = rsp_result_q;
  assign rsp_overflow = rsp_overflow_q;
  assign ovf_sticky   = ovf_sticky_q;

endmodule
